// File: rtl/bht_pkg.sv
// rtl/bht_pkg.sv - shared types and constants for the BHT access controller
package bht_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_e;

  localparam int BHT_INIT_PASSES = 3;
  localparam int BHT_IDX_W       = 5;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic                 taken;
  } bht_upd_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// rtl/bht_upd_fifo.sv - resolved-branch update queue with all entries exposed
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_flush,
  input  logic             i_push,
  input  bht_upd_t         i_push_data,
  input  logic             i_pop,
  output bht_upd_t         o_head,
  output logic             o_full,
  output logic             o_empty,
  output bht_upd_t         o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bht_upd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_entries = r_mem;

  // A slot is live when its distance from the read pointer is below the count
  always_comb begin
    logic [PTR_W-1:0] v_off;
    v_off   = '0;
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off      = PTR_W'(i) - r_rd_ptr;
      o_valid[i] = ({1'b0, v_off} < r_count);
    end
  end

endmodule

// File: rtl/bht_access_ctrl.sv
// rtl/bht_access_ctrl.sv - BHT init sweep plus fetch/update port arbitration
module bht_access_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 4,
  parameter int STARVE = 4
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_reinit,
  input  logic             i_upd_valid,
  output logic             o_upd_ready,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic             i_fetch_req,
  input  logic [IDX_W-1:0] i_fetch_idx,
  output logic             o_fetch_grant,
  output logic             o_fetch_pending,
  output logic             o_init_done,
  output logic             o_bht_rd_en,
  output logic             o_bht_wr_en,
  output logic [IDX_W-1:0] o_bht_idx,
  output logic             o_bht_wr_taken
);

  localparam int CNT_W      = IDX_W + 2;
  localparam int SWEEP_LAST = BHT_INIT_PASSES * (2 ** IDX_W) - 1;
  localparam int STV_W      = $clog2(STARVE + 1);

  bht_state_e       r_state;
  bht_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [STV_W-1:0] r_starve;

  logic             w_full;
  logic             w_empty;
  bht_upd_t         w_head;
  bht_upd_t         w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  bht_upd_t         w_push_data;

  logic w_run;
  logic w_sweep_last;
  logic w_force;
  logic w_grant;
  logic w_pop;
  logic w_ready;
  logic w_push;
  logic w_pending;

  bht_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_flush     (i_reinit),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_entries   (w_entries),
    .o_valid     (w_valid)
  );

  assign w_push_data = '{idx: BHT_IDX_W'(i_upd_idx), taken: i_upd_taken};

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= INIT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_reinit)                          w_next_state = INIT;
    else if (r_state == INIT && w_sweep_last) w_next_state = RUN;
  end

  // Fetch wins ties unless the queue is full or its head has waited STARVE cycles
  always_comb begin
    w_run        = (r_state == RUN);
    w_sweep_last = (r_cnt == CNT_W'(SWEEP_LAST));
    w_force      = !w_empty && (w_full || (r_starve == STV_W'(STARVE)));
    w_grant      = w_run && i_fetch_req && !w_force;
    w_pop        = w_run && !w_empty && (!i_fetch_req || w_force);
    w_ready      = w_run && !i_reinit && (!w_full || w_pop);
    w_push       = i_upd_valid && w_ready;
    w_pending    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].idx == BHT_IDX_W'(i_fetch_idx))) w_pending = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      if (i_reinit || w_run)      r_cnt <= '0;
      else                        r_cnt <= r_cnt + CNT_W'(1);
      if (i_reinit || w_empty || w_pop) r_starve <= '0;
      else                              r_starve <= r_starve + STV_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_bht_rd_en    <= 1'b0;
      o_bht_wr_en    <= 1'b0;
      o_bht_idx      <= '0;
      o_bht_wr_taken <= 1'b0;
    end else if (!w_run) begin
      o_bht_rd_en    <= 1'b0;
      o_bht_wr_en    <= 1'b1;
      o_bht_idx      <= r_cnt[IDX_W-1:0];
      o_bht_wr_taken <= 1'b0;
    end else if (w_pop) begin
      o_bht_rd_en    <= 1'b0;
      o_bht_wr_en    <= 1'b1;
      o_bht_idx      <= IDX_W'(w_head.idx);
      o_bht_wr_taken <= w_head.taken;
    end else begin
      o_bht_rd_en    <= w_grant;
      o_bht_wr_en    <= 1'b0;
      o_bht_idx      <= w_grant ? i_fetch_idx : '0;
      o_bht_wr_taken <= 1'b0;
    end
  end

  assign o_upd_ready     = w_ready;
  assign o_fetch_grant   = w_grant;
  assign o_fetch_pending = w_pending;
  assign o_init_done     = w_run;

endmodule

// File: tb/tb_bht_access_ctrl.sv
// tb/tb_bht_access_ctrl.sv - directed table-driven bench for bht_access_ctrl
module tb_bht_access_ctrl;

  logic       clk;
  logic       arst;
  logic       reinit;
  logic       upd_valid;
  logic       upd_ready;
  logic [4:0] upd_idx;
  logic       upd_taken;
  logic       fetch_req;
  logic [4:0] fetch_idx;
  logic       fetch_grant;
  logic       fetch_pending;
  logic       init_done;
  logic       bht_rd_en;
  logic       bht_wr_en;
  logic [4:0] bht_idx;
  logic       bht_wr_taken;

  int n_checks = 0;
  int n_err    = 0;

  bht_access_ctrl #(.IDX_W(5), .DEPTH(4), .STARVE(4)) dut (
    .i_clk           (clk),
    .i_arst          (arst),
    .i_reinit        (reinit),
    .i_upd_valid     (upd_valid),
    .o_upd_ready     (upd_ready),
    .i_upd_idx       (upd_idx),
    .i_upd_taken     (upd_taken),
    .i_fetch_req     (fetch_req),
    .i_fetch_idx     (fetch_idx),
    .o_fetch_grant   (fetch_grant),
    .o_fetch_pending (fetch_pending),
    .o_init_done     (init_done),
    .o_bht_rd_en     (bht_rd_en),
    .o_bht_wr_en     (bht_wr_en),
    .o_bht_idx       (bht_idx),
    .o_bht_wr_taken  (bht_wr_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fr;
    logic [4:0] fi;
    logic       uv;
    logic [4:0] ui;
    logic       ut;
    logic       eg;
    logic       er;
    logic       ep;
    logic       erd;
    logic       ewr;
    logic [4:0] eidx;
    logic       etk;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bht_word();
    return {bht_wr_en, bht_rd_en, bht_idx, bht_wr_taken};
  endfunction

  // Each iteration follows one sweep write; init_done and ready rise with the last one
  task automatic sweep(input int n);
    logic [10:0] exp;
    fetch_req = 1'b0;
    upd_valid = 1'b0;
    reinit    = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp = {(k == 95), 1'b1, 1'b0, 5'(k % 32), 1'b0, (k == 95), 1'b0};
      chk($sformatf("sweep_w%0d", k),
          {init_done, bht_wr_en, bht_rd_en, bht_idx, bht_wr_taken, upd_ready, fetch_grant}, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 1'b0};
    vecs[1] = '{1'b0, 5'd10, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};
    vecs[2] = '{1'b0, 5'd3,  1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  1'b1};
    vecs[3] = '{1'b0, 5'd9,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0};
    vecs[4] = '{1'b1, 5'd21, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd21, 1'b0};
    vecs[5] = '{1'b1, 5'd5,  1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0};
    vecs[6] = '{1'b0, 5'd5,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  1'b1};
    vecs[7] = '{1'b0, 5'd5,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};

    arst      = 1'b1;
    reinit    = 1'b0;
    upd_valid = 1'b1;
    upd_idx   = 5'd1;
    upd_taken = 1'b1;
    fetch_req = 1'b1;
    fetch_idx = 5'd2;
    #12;
    chk("reset_outputs",
        {init_done, bht_wr_en, bht_rd_en, bht_idx, bht_wr_taken, upd_ready, fetch_grant}, 11'd0);

    @(negedge clk);
    arst = 1'b0;
    sweep(96);

    for (int i = 0; i < 8; i++) begin
      fetch_req = vecs[i].fr;
      fetch_idx = vecs[i].fi;
      upd_valid = vecs[i].uv;
      upd_idx   = vecs[i].ui;
      upd_taken = vecs[i].ut;
      #4;
      chk($sformatf("v%0d_grant", i),   fetch_grant,   vecs[i].eg);
      chk($sformatf("v%0d_ready", i),   upd_ready,     vecs[i].er);
      chk($sformatf("v%0d_pending", i), fetch_pending, vecs[i].ep);
      @(posedge clk); #1;
      chk($sformatf("v%0d_bht", i), bht_word(),
          {vecs[i].ewr, vecs[i].erd, vecs[i].eidx, vecs[i].etk});
    end

    // Starvation bound: head is written on the fifth losing cycle
    fetch_req = 1'b1; fetch_idx = 5'd12;
    upd_valid = 1'b1; upd_idx = 5'd7; upd_taken = 1'b1;
    #4;
    chk("starve_push_ready", upd_ready, 1'b1);
    chk("starve_push_grant", fetch_grant, 1'b1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      #4;
      chk($sformatf("starve_grant_c%0d", j), fetch_grant, (j != 5));
      @(posedge clk); #1;
      chk($sformatf("starve_bht_c%0d", j), bht_word(),
          (j == 5) ? {1'b1, 1'b0, 5'd7, 1'b1} : {1'b0, 1'b1, 5'd12, 1'b0});
    end

    // Fill to full under fetch pressure, then push while the forced pop drains
    fetch_idx = 5'd20;
    for (int j = 0; j < 4; j++) begin
      upd_valid = 1'b1; upd_idx = 5'(j + 1); upd_taken = j[0];
      #4;
      chk($sformatf("fill_ready_%0d", j), upd_ready, 1'b1);
      chk($sformatf("fill_grant_%0d", j), fetch_grant, 1'b1);
      @(posedge clk); #1;
    end
    upd_idx = 5'd8; upd_taken = 1'b1; fetch_idx = 5'd3;
    #4;
    chk("full_pop_ready", upd_ready, 1'b1);
    chk("full_pop_grant", fetch_grant, 1'b0);
    chk("full_pending", fetch_pending, 1'b1);
    @(posedge clk); #1;
    chk("full_pop_bht", bht_word(), {1'b1, 1'b0, 5'd1, 1'b0});
    upd_valid = 1'b0; fetch_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      logic [4:0] e_idx [4];
      logic       e_tk  [4];
      e_idx = '{5'd2, 5'd3, 5'd4, 5'd8};
      e_tk  = '{1'b1, 1'b0, 1'b1, 1'b1};
      @(posedge clk); #1;
      chk($sformatf("drain_%0d", j), bht_word(), {1'b1, 1'b0, e_idx[j], e_tk[j]});
    end

    // Pending compare, then reinit with three entries queued
    fetch_req = 1'b1; fetch_idx = 5'd0;
    upd_valid = 1'b1; upd_idx = 5'd3;  upd_taken = 1'b0;
    @(posedge clk); #1;
    upd_idx = 5'd9;
    @(posedge clk); #1;
    upd_idx = 5'd11;
    @(posedge clk); #1;
    upd_idx = 5'd30; reinit = 1'b1; fetch_idx = 5'd9;
    #2;
    chk("pending_hit", fetch_pending, 1'b1);
    chk("reinit_ready", upd_ready, 1'b0);
    fetch_idx = 5'd4;
    #2;
    chk("pending_miss", fetch_pending, 1'b0);
    fetch_idx = 5'd9;
    @(posedge clk); #1;
    reinit = 1'b0; upd_valid = 1'b0; fetch_req = 1'b0;
    chk("reinit_init_done", init_done, 1'b0);
    chk("reinit_flushed", fetch_pending, 1'b0);
    sweep(96);
    fetch_idx = 5'd30;
    #4;
    chk("dropped_push", fetch_pending, 1'b0);
    @(posedge clk); #1;
    chk("post_reinit_idle", bht_word(), 8'd0);

    // Async reset in the middle of a sweep restarts it from index 0
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    sweep(40);
    arst = 1'b1; fetch_req = 1'b1;
    #1;
    chk("arst_mid_sweep",
        {init_done, bht_wr_en, bht_rd_en, bht_idx, bht_wr_taken, upd_ready, fetch_grant}, 11'd0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    sweep(96);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
